tia_biphase_clock: RTL and testbench
====================================

TIA_BIPHASE_CLOCK -- requirements
Module: tia_biphase_clock

Interface
REQ-001 Parameters: none; all timing is fixed by this spec.
REQ-002 One clock and one reset: the reset is asynchronous and active-high. Port names follow the codebase: clk for the clock, r for the reset.
REQ-003 clk  input  1  master (color) clock; all state changes on rising edge.
REQ-004 r  input  1  reset; asynchronous, active-high.
REQ-005 phi1  output  1  biphase clock phase 1, registered.
REQ-006 phi2  output  1  biphase clock phase 2, registered.
REQ-007 rl  output  1  latched reset; high while in reset, low once the phase sequence runs.

Function
REQ-008 Internal state SHALL be one of five states: RST, PH2, Z1, PH1, Z2.
REQ-009 State outputs SHALL be:
- RST: phi1=0, phi2=0, rl=1
- PH2: phi1=0, phi2=1, rl=0
- Z1: phi1=0, phi2=0, rl=0
- PH1: phi1=1, phi2=0, rl=0
- Z2: phi1=0, phi2=0, rl=0
REQ-010 Transitions SHALL occur on each rising clk edge while r=0: RST->PH2->Z1->PH1->Z2->PH2, cycling indefinitely.
REQ-011 The first rising clk edge sampling r=0 SHALL move RST to PH2, so phi2=1 and rl=0 become visible one clk period after reset release (1-cycle latency).
REQ-012 phi1 and phi2 SHALL never both be 1 in any state, including the reset and transition cycles.
REQ-013 Each phase high time and each non-overlap gap SHALL be exactly one clk period; the full biphase period SHALL be 4 clk periods (divide-by-4).
REQ-014 All outputs SHALL be driven directly from flops (no combinational decode glitches): phi1, phi2 and rl each registered.
REQ-015 Outputs SHALL be stable from one rising edge to the next; the falling clk edge SHALL have no effect.

Reset
REQ-016 r=1 SHALL asynchronously force state RST (phi1=0, phi2=0, rl=1) regardless of clk.
REQ-017 Reset asserted mid-sequence, in any state, SHALL immediately force RST. After release, the sequence SHALL restart at PH2 per REQ-011, never resuming mid-cycle.
REQ-018 While r stays 1, outputs SHALL hold their RST values across any number of clk edges.

Structure
REQ-019 State encoding constants (RST, PH2, Z1, PH1, Z2) SHALL live in a shared TIA package for reuse by benches and sibling TIA blocks.
REQ-020 The block SHALL be a single module with no sub-modules: one state register plus registered output decode.

Verification
REQ-021 Hold r=1 for 3 clk edges -> phi1=0, phi2=0, rl=1 throughout.
REQ-022 Release r before a rising edge -> after that edge phi2=1, phi1=0, rl=0. Subsequent edges give (phi1,phi2) = (0,0), (1,0), (0,0), (0,1), with rl=0 in all of them.
REQ-023 Run 40 clk cycles and sample phi1/phi2 on every rising and falling edge -> never both 1. Each phase is high for exactly 1 of every 4 cycles.
REQ-024 Assert r asynchronously (between edges) while in PH1 -> phi1 drops to 0 and rl rises to 1 before the next edge. After release, the first edge gives phi2=1.
REQ-025 Assert r during PH2, hold it for 2 edges, then release -> outputs stay (0,0,rl=1) during the hold. The sequence then restarts at PH2 with period 4.

Source files
------------

// File: rtl/tia_pkg.sv
// Shared TIA definitions: biphase clock state encoding and output decode.
package tia_pkg;

    // Biphase clock generator states, shared with benches and sibling TIA blocks.
    typedef enum logic [2:0] {
        RST = 3'd0,
        PH2 = 3'd1,
        Z1  = 3'd2,
        PH1 = 3'd3,
        Z2  = 3'd4
    } tia_clk_state_e;

    // Output bundle of the biphase generator.
    typedef struct packed {
        logic phi1;
        logic phi2;
        logic rl;
    } tia_clk_out_s;

    // Output values that belong to a given state.
    function automatic tia_clk_out_s tia_clk_decode(input tia_clk_state_e st);
        tia_clk_out_s o;
        o = '{phi1: 1'b0, phi2: 1'b0, rl: 1'b0};
        unique case (st)
            RST:     o.rl   = 1'b1;
            PH2:     o.phi2 = 1'b1;
            PH1:     o.phi1 = 1'b1;
            Z1, Z2:  o      = '{phi1: 1'b0, phi2: 1'b0, rl: 1'b0};
            default: o.rl   = 1'b1;
        endcase
        return o;
    endfunction

endpackage : tia_pkg

// File: rtl/tia_biphase_clock.sv
// Divide-by-4 non-overlapping biphase clock generator with latched reset flag.
// Sequence RST -> PH2 -> Z1 -> PH1 -> Z2 -> PH2 ..., each state lasting one clk.
module tia_biphase_clock
    import tia_pkg::*;
(
    input  logic clk,
    input  logic r,
    output logic phi1,
    output logic phi2,
    output logic rl
);

    tia_clk_state_e state_q, state_d;
    logic           phi1_q, phi1_d;
    logic           phi2_q, phi2_d;
    logic           rl_q,   rl_d;
    tia_clk_out_s   out_d;

    // Next state and the outputs that state will present; the decode is done
    // ahead of the register so every output comes straight from a flop.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            RST:     state_d = PH2;
            PH2:     state_d = Z1;
            Z1:      state_d = PH1;
            PH1:     state_d = Z2;
            Z2:      state_d = PH2;
            default: state_d = RST;
        endcase
        out_d  = tia_clk_decode(state_d);
        phi1_d = out_d.phi1;
        phi2_d = out_d.phi2;
        rl_d   = out_d.rl;
    end

    // State and output registers; reset forces RST immediately, independent of clk.
    always_ff @(posedge clk or posedge r) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (r) begin
            state_q <= RST;
            phi1_q  <= 1'b0;
            phi2_q  <= 1'b0;
            rl_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            phi1_q  <= phi1_d;
            phi2_q  <= phi2_d;
            rl_q    <= rl_d;
        end
    end

    assign phi1 = phi1_q;
    assign phi2 = phi2_q;
    assign rl   = rl_q;

endmodule : tia_biphase_clock

// File: tb/tb_tia_biphase_clock.sv
// Self-checking bench for tia_biphase_clock: vector table plus corner-case sequences.
module tb_tia_biphase_clock;

    logic clk;
    logic r;
    logic phi1, phi2, rl;

    int n_cmp;
    int n_err;

    typedef struct {
        logic r;
        logic exp_phi1;
        logic exp_phi2;
        logic exp_rl;
    } vec_t;

    vec_t vecs[9];

    tia_biphase_clock dut (
        .clk  (clk),
        .r    (r),
        .phi1 (phi1),
        .phi2 (phi2),
        .rl   (rl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {phi1,phi2,rl}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_no_overlap(input string name);
        n_cmp++;
        if (phi1 === 1'b1 && phi2 === 1'b1) begin
            n_err++;
            $display("FAIL %s: phi1=%b phi2=%b both high at %0t", name, phi1, phi2, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {phi1,phi2,rl} for the running sequence, indexed by position after PH2.
    function automatic logic [2:0] seq_exp(input int k);
        case (k % 4)
            0:       return 3'b010; // PH2
            1:       return 3'b000; // Z1
            2:       return 3'b100; // PH1
            default: return 3'b000; // Z2
        endcase
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        r = 1'b1;

        // Hold reset for 3 edges, release, then walk one full period.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 0, 1'b0};
        vecs[8].exp_phi2 = 1'b0; // Z1 after the second PH2

        #2;
        check("reset_initial", {phi1, phi2, rl}, 3'b001);

        for (int i = 0; i < 9; i++) begin
            r = vecs[i].r;
            step();
            check($sformatf("vec%0d", i), {phi1, phi2, rl},
                  {vecs[i].exp_phi1, vecs[i].exp_phi2, vecs[i].exp_rl});
        end
        // Now in Z1, i.e. sequence position 1.

        // 40-cycle run: compare on rising edges, confirm falling edges change nothing.
        begin
            int p1_cnt;
            int p2_cnt;
            logic [2:0] exp;
            p1_cnt = 0;
            p2_cnt = 0;
            for (int k = 2; k < 42; k++) begin
                exp = seq_exp(k);
                step();
                check($sformatf("run_rise%0d", k), {phi1, phi2, rl}, exp);
                check_no_overlap("overlap_rise");
                if (phi1 === 1'b1) p1_cnt++;
                if (phi2 === 1'b1) p2_cnt++;
                @(negedge clk);
                #1;
                check($sformatf("run_fall%0d", k), {phi1, phi2, rl}, exp);
                check_no_overlap("overlap_fall");
            end
            n_cmp++;
            if (p1_cnt != 10 || p2_cnt != 10) begin
                n_err++;
                $display("FAIL duty: phi1 high %0d, phi2 high %0d, expected 10 each", p1_cnt, p2_cnt);
            end
        end

        // Asynchronous reset while in PH1.
        begin
            int budget;
            budget = 0;
            while (phi1 !== 1'b1 && budget < 8) begin
                step();
                budget++;
            end
            n_cmp++;
            if (phi1 !== 1'b1) begin
                n_err++;
                $display("FAIL find_ph1: phi1=%b expected 1 within 8 cycles", phi1);
            end
        end
        #2;
        r = 1'b1;
        #1;
        check("async_rst_ph1", {phi1, phi2, rl}, 3'b001);
        @(negedge clk);
        r = 1'b0;
        step();
        check("restart_after_ph1_rst", {phi1, phi2, rl}, 3'b010);

        // Reset asserted during PH2, held over 2 edges, then released.
        #2;
        r = 1'b1;
        #1;
        check("async_rst_ph2", {phi1, phi2, rl}, 3'b001);
        step();
        check("hold_edge1", {phi1, phi2, rl}, 3'b001);
        step();
        check("hold_edge2", {phi1, phi2, rl}, 3'b001);
        r = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("restart_seq%0d", k), {phi1, phi2, rl}, seq_exp(k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_tia_biphase_clock
